ps2_key_decoder: RTL



---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_clk_filter.sv | 58 +++++
 rtl/ps2_key_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants and receive-FSM encoding shared by the PS/2 decoder
// and the snake controller.
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] S   = 8'h1B;
    localparam logic [7:0] P   = 8'h4D;
    localparam logic [7:0] R   = 8'h2D;
    localparam logic [7:0] ESC = 8'h76;
    localparam logic [7:0] Rt  = 8'h74;
    localparam logic [7:0] Lf  = 8'h6B;
    localparam logic [7:0] Up  = 8'h75;
    localparam logic [7:0] Dn  = 8'h72;
    localparam logic [7:0] E0  = 8'hE0;
    localparam logic [7:0] F0  = 8'hF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    // Bit order of the key-level vector: start, pause, resume, stop, up, dn, lf, rt.
    function automatic logic [7:0] key_mask(input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case (code)
            S:       m = 8'h01;
            P:       m = 8'h02;
            R:       m = 8'h04;
            ESC:     m = 8'h08;
            Up:      m = 8'h10;
            Dn:      m = 8'h20;
            Lf:      m = 8'h40;
            Rt:      m = 8'h80;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises the PS/2 lines, debounces the clock over FILTER_LEN
// samples and emits a one-cycle strobe on each filtered falling edge.
`default_nettype none

module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q;

    // Any sample equal to the current filtered level restarts the run count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= filt_q & ~filt_d;
        end
    end

    assign fall_o = fall_q;
    assign data_o = data_sync_q[1];

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver and make/break decoder driving held key levels.
// Optional saturating error counter port err_cnt when PS2_KEY_DECODER_ERR_CNT_EN is defined.
`default_nettype none

module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN    = 8,
    parameter int FRAME_TIMEOUT = 200000
) (
    input  logic       clk100Mhz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       key_start,
    output logic       key_pause,
    output logic       key_resume,
    output logic       key_stop,
    output logic       key_up,
    output logic       key_dn,
    output logic       key_lf,
    output logic       key_rt
`ifdef PS2_KEY_DECODER_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int TMO_W = $clog2(FRAME_TIMEOUT + 1);

    logic strobe;
    logic rx_data;

    rx_state_t        state_q, state_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       scan_q, scan_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [7:0]       keys_q, keys_d;
    logic [7:0]       hit_mask;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk_i     (clk100Mhz),
        .rst_i     (reset),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .fall_o    (strobe),
        .data_o    (rx_data)
    );

    assign hit_mask = key_mask(scan_q);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tmo_d    = tmo_q;
        scan_d   = scan_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        ext_d    = ext_q;
        brk_d    = brk_q;
        keys_d   = keys_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (strobe && !rx_data) begin
                    state_d  = SHIFT;
                    bitcnt_d = 4'd1;
                end
            end
            SHIFT: begin
                // A strobe landing on the terminal count still counts as progress.
                if (strobe) begin
                    shift_d  = {rx_data, shift_q[9:1]};
                    tmo_d    = '0;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd10) begin
                        state_d = CHECK;
                    end
                end else if (tmo_q == TMO_W'(FRAME_TIMEOUT)) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CHECK: begin
                // shift_q holds {stop, parity, data[7:0]}; odd parity over data+parity.
                if ((^shift_q[8:0]) && shift_q[9]) begin
                    scan_d  = shift_q[7:0];
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (valid_q) begin
            if (scan_q == E0) begin
                ext_d = 1'b1;
            end else if (scan_q == F0) begin
                brk_d = 1'b1;
            end else begin
                keys_d = brk_q ? (keys_q & ~hit_mask) : (keys_q | hit_mask);
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk100Mhz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= 4'd0;
            shift_q  <= 10'd0;
            tmo_q    <= '0;
            scan_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            keys_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            tmo_q    <= tmo_d;
            scan_q   <= scan_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            keys_q   <= keys_d;
        end
    end

`ifdef PS2_KEY_DECODER_ERR_CNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge clk100Mhz or posedge reset) begin
        if (reset) begin
            errcnt_q <= 8'd0;
        end else if (err_q && errcnt_q != 8'hFF) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign err_cnt = errcnt_q;
`endif

    assign scan_code  = scan_q;
    assign code_valid = valid_q;
    assign frame_err  = err_q;
    assign key_start  = keys_q[0];
    assign key_pause  = keys_q[1];
    assign key_resume = keys_q[2];
    assign key_stop   = keys_q[3];
    assign key_up     = keys_q[4];
    assign key_dn     = keys_q[5];
    assign key_lf     = keys_q[6];
    assign key_rt     = keys_q[7];

endmodule

`default_nettype wire
